// File: rtl/boreal_chan_sched_if.sv
// Handshake bundle between frame capture, the channel sequencer and the weight-update core.
// The sequencer takes the slave side; the frame/core environment takes the master side.
interface boreal_chan_sched_if #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3,
  parameter int OVR_W  = 16
);
  logic              frame_valid;
  logic [NUM_CH-1:0] ch_mask;
  logic              inhibit;
  logic              core_ready;
  logic              core_done;
  logic              err_clr;
  logic              core_start;
  logic [CH_W-1:0]   core_ch;
  logic              busy;
  logic              frame_done;
  logic [OVR_W-1:0]  ovr_cnt;
  logic              timeout_err;

  modport master (
    output frame_valid, ch_mask, inhibit, core_ready, core_done, err_clr,
    input  core_start, core_ch, busy, frame_done, ovr_cnt, timeout_err
  );

  modport slave (
    input  frame_valid, ch_mask, inhibit, core_ready, core_done, err_clr,
    output core_start, core_ch, busy, frame_done, ovr_cnt, timeout_err
  );
endinterface

// File: rtl/boreal_chan_sched.sv
// Per-frame channel sequencer: walks the enabled channels in ascending order,
// starting the shared weight-update core once per channel and waiting for its done.
module boreal_chan_sched #(
  parameter int NUM_CH  = 8,
  parameter int CH_W    = 3,
  parameter int TIMEOUT = 255,
  parameter int OVR_W   = 16
) (
  input logic               clk_100m,
  input logic               rst,
  boreal_chan_sched_if.slave bus
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, FIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [NUM_CH-1:0] pend;
  logic [TMR_W-1:0]  timer;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   low_idx;
  logic [OVR_W-1:0]  ovr_q;
  logic              err_q;
  logic              timer_hit;
  logic              start_c;
  logic              busy_c;
  logic              fdone_c;

  assign timer_hit = (timer == TMR_LAST);

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_valid && !bus.inhibit) state_nxt = SCAN;
      SCAN:    state_nxt = ((pend == '0) || bus.inhibit) ? FIN : ISSUE;
      ISSUE:   if (bus.core_ready) state_nxt = WAIT;
      WAIT: begin
        if (bus.core_done) state_nxt = SCAN;
        else if (timer_hit) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_c = 1'b0;
    busy_c  = (state != IDLE);
    fdone_c = (state == FIN);
    if (state == ISSUE) start_c = bus.core_ready;
  end

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = CH_W'(i);
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      pend  <= '0;
      timer <= '0;
      ch_q  <= '0;
      ovr_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.frame_valid && !bus.inhibit) pend <= bus.ch_mask;
        SCAN: begin
          if (bus.inhibit) pend <= '0;
          else if (pend != '0) ch_q <= low_idx;
        end
        ISSUE: begin
          if (bus.core_ready) begin
            pend[ch_q] <= 1'b0;
            timer      <= '0;
          end
        end
        WAIT: begin
          if (!bus.core_done) begin
            timer <= timer + 1'b1;
            if (timer_hit) pend <= '0;
          end
        end
        default: ;
      endcase

      if (bus.frame_valid && (state != IDLE) && (ovr_q != '1)) ovr_q <= ovr_q + 1'b1;

      // A timeout on the same cycle as err_clr keeps the error set.
      if ((state == WAIT) && !bus.core_done && timer_hit) err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.core_start  = start_c;
  assign bus.busy        = busy_c;
  assign bus.frame_done  = fdone_c;
  assign bus.core_ch     = ch_q;
  assign bus.ovr_cnt     = ovr_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_boreal_chan_sched.sv
// Directed bench for boreal_chan_sched (TIMEOUT=16, OVR_W=2): expected core starts are
// queued when a frame is launched and popped by a monitor as the DUT issues them.
module tb_boreal_chan_sched;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   n_starts = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb_head;

  boreal_chan_sched_if #(.NUM_CH(8), .CH_W(3), .OVR_W(2)) bus ();

  boreal_chan_sched #(
    .NUM_CH (8),
    .CH_W   (3),
    .TIMEOUT(16),
    .OVR_W  (2)
  ) dut (
    .clk_100m(clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Every issued start must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.core_start === 1'b1) begin
      n_starts++;
      if (sb.size() == 0) begin
        check_output("unexpected_start_ch", int'(bus.core_ch), -1);
      end else begin
        sb_head = sb.pop_front();
        check_output("start_ch", int'(bus.core_ch), sb_head.ch);
        if (sb_head.cyc >= 0) check_output("start_cyc", cyc, sb_head.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] mask);
    bus.ch_mask     = mask;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
  endtask

  task automatic push_exp(input int ch, input int when);
    exp_t e;
    e.ch  = ch;
    e.cyc = when;
    sb.push_back(e);
  endtask

  task automatic wait_start(output int s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.core_start !== 1'b1 && n < 64);
    check_output("start_seen", int'(bus.core_start), 1);
    s = cyc;
  endtask

  task automatic wait_frame_done(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 64);
    check_output("frame_done_seen", int'(bus.frame_done), 1);
    c = cyc;
  endtask

  task automatic done_pulse();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
  endtask

  task automatic service_one();
    int s;
    wait_start(s);
    repeat (4) tick();
    done_pulse();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, s, s1, c, fd0, st0;

    rst             = 1'b1;
    bus.frame_valid = 1'b0;
    bus.ch_mask     = '0;
    bus.inhibit     = 1'b0;
    bus.core_ready  = 1'b0;
    bus.core_done   = 1'b0;
    bus.err_clr     = 1'b0;
    tick();

    // Reset held with inputs toggling.
    for (int i = 0; i < 3; i++) begin
      bus.frame_valid = 1'($urandom_range(0, 1));
      bus.core_ready  = 1'($urandom_range(0, 1));
      bus.core_done   = 1'($urandom_range(0, 1));
      bus.inhibit     = 1'($urandom_range(0, 1));
      bus.ch_mask     = 8'($urandom);
      @(negedge clk);
      check_output("rst_core_start", int'(bus.core_start), 0);
      check_output("rst_busy", int'(bus.busy), 0);
      check_output("rst_frame_done", int'(bus.frame_done), 0);
      check_output("rst_ovr_cnt", int'(bus.ovr_cnt), 0);
      check_output("rst_timeout_err", int'(bus.timeout_err), 0);
      check_output("rst_core_ch", int'(bus.core_ch), 0);
      tick();
    end
    rst             = 1'b0;
    bus.frame_valid = 1'b0;
    bus.core_ready  = 1'b0;
    bus.core_done   = 1'b0;
    bus.inhibit     = 1'b0;
    bus.ch_mask     = '0;
    tick();
    tick();

    // Mask A5: channels 0,2,5,7 six cycles apart.
    $display("[TB] mask A5 sweep");
    bus.core_ready = 1'b1;
    fd0 = fd_cnt;
    st0 = n_starts;
    t0  = cyc;
    push_exp(0, t0 + 2);
    push_exp(2, t0 + 8);
    push_exp(5, t0 + 14);
    push_exp(7, t0 + 20);
    apply_stimulus(8'hA5);
    for (int i = 0; i < 4; i++) service_one();
    wait_frame_done(c);
    check_output("a5_frame_done_cyc", c, t0 + 26);
    check_output("a5_busy_at_fin", int'(bus.busy), 1);
    tick();
    @(negedge clk);
    check_output("a5_busy_after", int'(bus.busy), 0);
    check_output("a5_frame_count", fd_cnt - fd0, 1);
    check_output("a5_start_count", n_starts - st0, 4);

    // Overrun during WAIT with all channels enabled.
    $display("[TB] overrun and saturation");
    tick();
    fd0 = fd_cnt;
    st0 = n_starts;
    t0  = cyc;
    push_exp(0, t0 + 2);
    for (int i = 1; i < 8; i++) push_exp(i, -1);
    apply_stimulus(8'hFF);
    wait_start(s);
    tick();
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick();
    tick();
    done_pulse();
    for (int i = 1; i < 8; i++) service_one();
    wait_frame_done(c);
    tick();
    @(negedge clk);
    check_output("ff_ovr_cnt", int'(bus.ovr_cnt), 1);
    check_output("ff_start_count", n_starts - st0, 8);
    check_output("ff_frame_count", fd_cnt - fd0, 1);

    // Core held not-ready in ISSUE while further frames overrun.
    tick();
    bus.core_ready = 1'b0;
    apply_stimulus(8'h01);
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.frame_valid = (i < 5);
      @(negedge clk);
      check_output("held_start", int'(bus.core_start), 0);
      if (i == 1) check_output("ovr_step", int'(bus.ovr_cnt), 2);
      tick();
    end
    bus.frame_valid = 1'b0;
    @(negedge clk);
    check_output("ovr_saturated", int'(bus.ovr_cnt), 3);
    tick();
    push_exp(0, cyc);
    bus.core_ready = 1'b1;
    service_one();
    wait_frame_done(c);
    tick();

    // Timeout on ch0; ch1 never issued.
    $display("[TB] timeout");
    fd0 = fd_cnt;
    st0 = n_starts;
    t0  = cyc;
    push_exp(0, t0 + 2);
    apply_stimulus(8'h03);
    wait_start(s);
    repeat (16) tick();
    @(negedge clk);
    check_output("to_err_before", int'(bus.timeout_err), 0);
    check_output("to_busy_wait", int'(bus.busy), 1);
    tick();
    @(negedge clk);
    check_output("to_frame_done", int'(bus.frame_done), 1);
    check_output("to_err_set", int'(bus.timeout_err), 1);
    tick();
    @(negedge clk);
    check_output("to_busy_after", int'(bus.busy), 0);
    check_output("to_frame_count", fd_cnt - fd0, 1);
    check_output("to_start_count", n_starts - st0, 1);
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    @(negedge clk);
    check_output("err_cleared", int'(bus.timeout_err), 0);

    // Timeout while err_clr is held: the set wins.
    tick();
    bus.err_clr = 1'b1;
    t0 = cyc;
    push_exp(0, t0 + 2);
    apply_stimulus(8'h03);
    wait_start(s);
    repeat (17) tick();
    @(negedge clk);
    check_output("set_wins", int'(bus.timeout_err), 1);
    tick();
    @(negedge clk);
    check_output("clr_after_set", int'(bus.timeout_err), 0);
    bus.err_clr = 1'b0;

    // core_done on the final timer cycle beats the timeout.
    tick();
    t0 = cyc;
    push_exp(0, t0 + 2);
    apply_stimulus(8'h03);
    wait_start(s);
    repeat (16) tick();
    push_exp(1, s + 18);
    done_pulse();
    @(negedge clk);
    check_output("done_wins_err", int'(bus.timeout_err), 0);
    wait_start(s1);
    repeat (4) tick();
    done_pulse();
    wait_frame_done(c);
    check_output("done_wins_err_end", int'(bus.timeout_err), 0);
    tick();

    // Reset mid-frame abandons it without frame_done.
    $display("[TB] mid-frame reset");
    fd0 = fd_cnt;
    t0  = cyc;
    push_exp(0, t0 + 2);
    apply_stimulus(8'hFF);
    wait_start(s);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("mrst_busy", int'(bus.busy), 0);
    check_output("mrst_ovr_cnt", int'(bus.ovr_cnt), 0);
    repeat (3) tick();
    check_output("mrst_frame_count", fd_cnt - fd0, 0);

    // Inhibited frame is dropped without counting an overrun.
    $display("[TB] inhibit");
    st0 = n_starts;
    bus.inhibit = 1'b1;
    apply_stimulus(8'hFF);
    repeat (3) tick();
    @(negedge clk);
    check_output("inh_busy", int'(bus.busy), 0);
    check_output("inh_ovr_cnt", int'(bus.ovr_cnt), 0);
    check_output("inh_start_count", n_starts - st0, 0);
    tick();
    bus.inhibit = 1'b0;

    // Inhibit raised in WAIT: ch0 completes, ch1 skipped.
    fd0 = fd_cnt;
    st0 = n_starts;
    t0  = cyc;
    push_exp(0, t0 + 2);
    apply_stimulus(8'h03);
    wait_start(s);
    tick();
    bus.inhibit = 1'b1;
    repeat (3) tick();
    done_pulse();
    wait_frame_done(c);
    check_output("inh_wait_fd_cyc", c, s + 6);
    tick();
    bus.inhibit = 1'b0;
    tick();
    check_output("inh_wait_starts", n_starts - st0, 1);
    check_output("inh_wait_frames", fd_cnt - fd0, 1);

    // Empty mask finishes in cycle 2 with no start.
    $display("[TB] empty mask");
    st0 = n_starts;
    t0  = cyc;
    apply_stimulus(8'h00);
    wait_frame_done(c);
    check_output("empty_fd_cyc", c, t0 + 2);
    repeat (3) tick();
    check_output("empty_starts", n_starts - st0, 0);
    check_output("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
